// File: rtl/pwm_meas.sv
// pwm_meas: measures high time and period of a sub-clock-sampled PWM line.
// Outputs use the HR generator fixed-point format (HRBITS fraction bits).
module pwm_meas #(
  parameter int WIDTH  = 20,
  parameter int HRBITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [(1<<HRBITS)-1:0] sampD,
  input  logic                   en,
  output logic [WIDTH-1:0]       high_time,
  output logic [WIDTH-1:0]       period,
  output logic                   meas_valid,
  output logic                   timeout,
  output logic                   level,
  output logic                   err
);

  localparam int N  = 1 << HRBITS;
  localparam int CW = WIDTH - HRBITS;
  localparam int PW = HRBITS + 1;

  typedef enum logic {ACQ, RUN} state_t;

  state_t            state;
  logic              prev_msb;
  logic [HRBITS-1:0] start_pos;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  acc;

  logic [N:0]        ext;
  logic [N-1:0]      rise;
  logic              any_edge;
  logic              multi;
  logic              found;
  logic [HRBITS-1:0] pos;
  logic [HRBITS-1:0] last;
  logic [PW-1:0]     ones_all;
  logic [PW-1:0]     ones_lo;
  logic [PW-1:0]     ones_hi;
  logic [PW-1:0]     ones_last;
  logic [WIDTH-1:0]  per_nxt;
  logic [WIDTH-1:0]  ht_nxt;

  assign ext      = {sampD, prev_msb};
  assign rise     = ~ext[N-1:0] & ext[N:1];
  assign any_edge = |rise;
  assign multi    = |(rise & (rise - 1'b1));

  always_comb begin
    pos   = '0;
    last  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rise[i]) begin
        if (!found) pos = HRBITS'(i);
        found = 1'b1;
        last  = HRBITS'(i);
      end
    end
  end

  // Split the word's ones around the first and last edge positions.
  always_comb begin
    ones_all  = '0;
    ones_lo   = '0;
    ones_last = '0;
    for (int i = 0; i < N; i++) begin
      ones_all = ones_all + PW'(sampD[i]);
      if (i < int'(pos))
        ones_lo = ones_lo + PW'(sampD[i]);
      if (i >= int'(last))
        ones_last = ones_last + PW'(sampD[i]);
    end
    ones_hi = ones_all - ones_lo;
  end

  assign per_nxt = {cnt, {HRBITS{1'b0}}} + WIDTH'(N)
                 + WIDTH'(pos) - WIDTH'(start_pos);
  assign ht_nxt  = acc + WIDTH'(ones_lo);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACQ;
      prev_msb   <= 1'b1;
      start_pos  <= '0;
      cnt        <= '0;
      acc        <= '0;
      high_time  <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      level      <= 1'b0;
      err        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      prev_msb   <= sampD[N-1];
      if (!en) begin
        state <= ACQ;
      end else begin
        unique case (state)
          ACQ: begin
            if (any_edge) begin
              start_pos <= pos;
              cnt       <= '0;
              acc       <= WIDTH'(ones_hi);
              state     <= RUN;
            end
          end
          RUN: begin
            if (!any_edge) begin
              if (&cnt) begin
                timeout <= 1'b1;
                level   <= sampD[N-1];
                state   <= ACQ;
              end else begin
                cnt <= cnt + 1'b1;
                acc <= acc + WIDTH'(ones_all);
              end
            end else if (multi) begin
              err       <= 1'b1;
              start_pos <= pos;
              cnt       <= '0;
              acc       <= WIDTH'(ones_last);
            end else begin
              period     <= per_nxt;
              high_time  <= ht_nxt;
              meas_valid <= 1'b1;
              start_pos  <= pos;
              cnt        <= '0;
              acc        <= WIDTH'(ones_hi);
            end
          end
          default: state <= ACQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_meas.sv
// tb_pwm_meas: table vectors, directed corners and random PWM streams
// checked against a phase-level reference model.
module tb_pwm_meas;

  localparam int W  = 12;
  localparam int HB = 3;
  localparam int CW = W - HB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   sampD = '0;
  logic         en = 1'b0;
  logic [W-1:0] high_time;
  logic [W-1:0] period;
  logic         meas_valid;
  logic         timeout;
  logic         level;
  logic         err;

  pwm_meas #(.WIDTH(W), .HRBITS(HB)) dut (
    .clk(clk), .rst(rst), .sampD(sampD), .en(en),
    .high_time(high_time), .period(period),
    .meas_valid(meas_valid), .timeout(timeout),
    .level(level), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: absolute phase positions on the sampled line
  bit           m_run;
  logic         m_prev;
  longint       wi, st_abs, st_word;
  int           ones;
  logic         m_v, m_to, m_lvl, m_err;
  logic [W-1:0] m_ht, m_pr;

  function automatic void model_reset();
    m_run = 0; m_prev = 1'b1; ones = 0;
    st_abs = 0; st_word = 0;
    m_v = 0; m_to = 0; m_lvl = 0; m_err = 0;
    m_ht = '0; m_pr = '0;
  endfunction

  function automatic void model_word(logic [7:0] w, logic e, logic r);
    int ne, fe, le, lo, hi, hl, tot;
    logic pb;
    m_v = 0; m_to = 0;
    if (r) begin
      model_reset();
      wi++;
      return;
    end
    ne = 0; fe = 0; le = 0;
    for (int i = 0; i < 8; i++) begin
      pb = (i == 0) ? m_prev : w[i-1];
      if (!pb && w[i]) begin
        if (ne == 0) fe = i;
        le = i;
        ne++;
      end
    end
    lo = 0; hi = 0; hl = 0; tot = 0;
    for (int i = 0; i < 8; i++) begin
      tot += int'(w[i]);
      if (i < fe) lo += int'(w[i]);
      else hi += int'(w[i]);
      if (i >= le) hl += int'(w[i]);
    end
    if (!e) begin
      m_run = 0;
    end else if (!m_run) begin
      if (ne > 0) begin
        m_run = 1; st_abs = wi * 8 + fe; st_word = wi; ones = hi;
      end
    end else if (ne == 0) begin
      if (wi - st_word == (longint'(1) << CW)) begin
        m_to = 1; m_lvl = w[7]; m_run = 0;
      end else begin
        ones += tot;
      end
    end else if (ne == 1) begin
      m_pr = W'(wi * 8 + fe - st_abs);
      m_ht = W'(ones + lo);
      m_v = 1;
      st_abs = wi * 8 + fe; st_word = wi; ones = hi;
    end else begin
      m_err = 1;
      st_abs = wi * 8 + fe; st_word = wi; ones = hl;
    end
    m_prev = w[7];
    wi++;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] w, input logic e, input logic r);
    @(negedge clk);
    sampD = w; en = e; rst = r;
    model_word(w, e, r);
    @(posedge clk);
    #1;
    chk("model", {meas_valid, timeout, level, err, high_time, period},
        {m_v, m_to, m_lvl, m_err, m_ht, m_pr});
  endtask

  typedef struct {
    logic [7:0]   w;
    logic         v;
    logic [W-1:0] ht;
    logic [W-1:0] pr;
    logic         e;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [7:0] w, logic v, int ht, int pr,
                              logic e);
    vec_t x;
    x.w = w; x.v = v; x.ht = W'(ht); x.pr = W'(pr); x.e = e;
    tbl.push_back(x);
  endfunction

  int nv, nt;
  logic [7:0] gw;
  int rl;
  logic lv;

  initial begin
    wi = 0;
    model_reset();
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    chk("reset_out", {meas_valid, timeout, level, err, high_time, period},
        64'h0);

    // drift 5->2, ones below edge, 1100_0011 close, double-edge error
    add(8'h00, 0, 0, 0, 0);
    add(8'hE0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) add(8'hFF, 0, 0, 0, 0);
    add(8'hFD, 1, 76, 77, 0);
    add(8'hFF, 0, 76, 77, 0);
    add(8'hFF, 0, 76, 77, 0);
    add(8'hC3, 1, 24, 28, 0);
    add(8'h00, 0, 24, 28, 0);
    add(8'h50, 0, 24, 28, 1);
    for (int i = 0; i < 3; i++) add(8'h00, 0, 24, 28, 1);
    add(8'hF0, 1, 1, 32, 1);
    add(8'h00, 0, 1, 32, 1);
    add(8'hF0, 1, 4, 16, 1);
    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].w, 1'b1, 1'b0);
      chk($sformatf("tbl%0d", k),
          {meas_valid, err, high_time, period},
          {tbl[k].v, tbl[k].e, tbl[k].ht, tbl[k].pr});
    end

    // generator loopback: PRD=255, cmpA=100, edge at phase 0
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b0);
    nv = 0;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 256; c++) begin
        for (int i = 0; i < 8; i++) gw[i] = (c * 8 + i) < 100;
        step(gw, 1'b1, 1'b0);
        if (meas_valid) begin
          nv++;
          chk("gen_period", period, 2048);
          chk("gen_high", high_time, 100);
        end
      end
    end
    chk("gen_nvalid", nv, 3);

    // timeout after a full counter of idle words
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b0);
    step(8'hF0, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    step(8'hF0, 1'b1, 1'b0);
    nt = 0;
    for (int i = 0; i < (1 << CW) + 4; i++) begin
      step(8'h00, 1'b1, 1'b0);
      if (timeout) begin
        nt++;
        chk("to_level", level, 0);
        chk("to_hold", {high_time, period}, {12'd4, 12'd16});
      end
    end
    chk("to_count", nt, 1);
    nv = 0;
    step(8'hF0, 1'b1, 1'b0);
    nv += int'(meas_valid);
    step(8'h00, 1'b1, 1'b0);
    nv += int'(meas_valid);
    chk("to_reacq_novalid", nv, 0);
    step(8'hF0, 1'b1, 1'b0);
    chk("to_reacq_valid", {meas_valid, period}, {1'b1, 12'd16});

    // reset one clock before a closing word
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1);
    chk("rst_mid_out", {meas_valid, timeout, level, err, high_time, period},
        64'h0);
    step(8'hF0, 1'b1, 1'b0);
    chk("rst_mid_close", {meas_valid, high_time, period}, 64'h0);

    // line already high at reset release
    step(8'hFF, 1'b1, 1'b1);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      nv += int'(meas_valid);
    end
    step(8'h00, 1'b1, 1'b0);
    nv += int'(meas_valid);
    step(8'hFF, 1'b1, 1'b0);
    nv += int'(meas_valid);
    chk("high_rst_novalid", nv, 0);
    for (int i = 0; i < 3; i++) step(8'hFF, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    chk("high_rst_first", {meas_valid, high_time, period},
        {1'b1, 12'd32, 12'd40});

    // random PWM-like streams with occasional enable drops
    step(8'h00, 1'b1, 1'b1);
    lv = 0; rl = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (--rl == 0) begin
          lv = ~lv;
          rl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3)
                                           : $urandom_range(4, 90);
        end
        gw[i] = lv;
      end
      step(gw, ($urandom_range(0, 63) != 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_meas.md
Name: pwm_meas

Overview:
- Measures a high-resolution PWM waveform, the receive-side counterpart of the team's HR PWM generator.
- Input is a per-clock parallel sample word, 2^HRBITS sub-clock phases per clock, as delivered by a deserializer from the pad.
- Once per PWM period it reports high time and period in the generator's fixed-point format: WIDTH bits, with HRBITS fractional (sub-clock) bits.
- Used for loopback self-test of the generator outputs and for external duty measurement.

Parameters:
- WIDTH, 20, width of measurement outputs; upper WIDTH-HRBITS bits count clocks, lower HRBITS bits count sub-clock phases.
- HRBITS, 3, log2 of phases per clock; sample word is 1<<HRBITS bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sampD  in  (1<<HRBITS)  sample word; bit 0 is the earliest phase, the MSB is the latest.
- en  in  1  measurement enable; low forces state ACQ.
- high_time  out  WIDTH  high duration of the last completed period, in sub-clock phases.
- period  out  WIDTH  rising-to-rising duration of the last completed period, in sub-clock phases.
- meas_valid  out  1  one-cycle pulse when high_time/period update.
- timeout  out  1  one-cycle pulse when no rising edge is seen within the counter range.
- level  out  1  sampD MSB of the timeout word, registered on timeout (the stuck level).
- err  out  1  sticky; set on more than one rising edge within one word; cleared by rst only.

Behaviour:
- Reset values: all outputs 0; state ACQ; prev_msb=1, so a line already high at reset gives no false edge; coarse counter 0; accumulator 0.
- Edge detect per word, combinational: ext = {sampD, prev_msb}. A rising edge at position p means ext[p]=0 and ext[p+1]=1.
  - pos = lowest such p, range 0..(1<<HRBITS)-1.
  - nedge = number of such p.
  - prev_msb <= sampD MSB every cycle.
- Sub-clock split of a word with an edge at pos:
  - ones_lo = popcount(sampD bits below pos).
  - ones_hi = popcount(sampD bits pos and above).
- State ACQ: wait for a word with nedge>=1.
  - On that word: start_pos <= pos, cnt <= 0, acc <= ones_hi, go to RUN.
  - No output update.
- State RUN, word with nedge==0:
  - acc <= acc + popcount(sampD).
  - cnt <= cnt+1.
- State RUN, word with nedge==1 (period close):
  - Next cycle: period = {cnt+1, HRBITS'b0} + pos - start_pos, evaluated in WIDTH bits, no wrap for in-range periods.
  - Next cycle: high_time = acc + ones_lo.
  - Next cycle: meas_valid=1.
  - Then start_pos <= pos, acc <= ones_hi, cnt <= 0; stay in RUN.
- Latency: outputs update and meas_valid pulses exactly 1 clk after the closing word is presented.
- The first valid follows the second rising edge after entering RUN; the first edge only opens a period.
- State RUN, word with nedge>=2:
  - Set err.
  - Discard the open period; no meas_valid.
  - Restart with start_pos=pos of the first edge, acc = popcount(bits at or above the last edge), cnt=0.
- Timeout: in RUN, a word with nedge==0 while cnt is all ones does the following:
  - timeout pulses next cycle.
  - level <= sampD MSB.
  - State goes to ACQ.
  - high_time and period hold their previous values.
- en low: state goes to ACQ next cycle and the open period is discarded. prev_msb keeps tracking. Outputs hold; no pulses.
- rst mid-operation: all state and outputs return to reset values on the next clk edge, including clearing err.
- high_time never exceeds period for a legal waveform. Both hold between updates.

Test Plan:
- HRBITS=3, period 256 clk, high 100 phases, edge at phase 0. Generator cmpA=100 with PRD=255 looped to sampD, for 4 periods -> 3 meas_valid pulses, each period=2048, high_time=100.
- Edge drifts between phases: start edge phase 5, next edge phase 2, 10 clk apart -> period=77. Bits before the edge in the closing word go to the old period (high_time check).
- Word 8'b1100_0011 (bit0 first) closing a period -> ones_lo=2 added to old high_time; new acc starts at 2.
- Word 8'b0101_0000 in RUN -> err=1 sticky, no meas_valid for that period, next clean period measures correctly.
- sampD held 0 for 2^(WIDTH-HRBITS) clks in RUN -> one timeout pulse, level=0, prior outputs held. Then a rising edge returns to RUN and the first valid comes after a second edge.
- rst asserted one clk before a closing word -> no meas_valid; all outputs 0. Line high at reset release -> no period starts until a low-to-high transition.
